// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART transmit-side types: arbiter FSM encoding and packet-length defaults.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int UART_MAX_PKT = 64;
    localparam int UART_CNT_W   = 7;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Two-source byte bus plus transmit FIFO write port.
// slave: arbiter side; master: sources and FIFO side.
interface uart_tx_arb_if;

    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       last0;
    logic       last1;
    logic       ack0;
    logic       ack1;
    logic       full;
    logic       wr;
    logic [7:0] wr_data;

    modport slave (
        input  req0, req1, data0, data1, last0, last1, full,
        output ack0, ack1, wr, wr_data
    );

    modport master (
        output req0, req1, data0, data1, last0, last1, full,
        input  ack0, ack1, wr, wr_data
    );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: packet-atomic arbiter of two byte sources onto one UART TX FIFO (optional UART_TX_ARB_FIXED_PRIO_EN).
// Latency: one IDLE cycle before the first byte of a packet; ack/wr/wr_data are combinational after that.
// Backpressure: full stalls acceptance; FSM and byte counter hold until it clears.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int MAX_PKT = UART_MAX_PKT,
    parameter int CNT_W   = UART_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arb_if.slave       bus,
    input  logic               err_clr,
    output logic               busy,
    output logic               owner,
    output logic               err
);

    arb_state_t       state;
    arb_state_t       both_grant;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             xfer_last;
    logic             force_rel;

    assign bus.ack0    = (state == LOCK0) && bus.req0 && !bus.full;
    assign bus.ack1    = (state == LOCK1) && bus.req1 && !bus.full;
    assign bus.wr      = bus.ack0 | bus.ack1;
    assign bus.wr_data = (state == LOCK1) ? bus.data1 : bus.data0;

    assign xfer      = bus.ack0 | bus.ack1;
    assign xfer_last = (state == LOCK1) ? bus.last1 : bus.last0;
    // A packet that reaches MAX_PKT bytes without last is cut off here.
    assign force_rel = xfer && !xfer_last && (cnt == CNT_W'(MAX_PKT - 1));

    assign busy  = (state != IDLE);
    assign owner = (state == LOCK1);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign both_grant = LOCK0;
`else
    logic rr_last;

    assign both_grant = rr_last ? LOCK0 : LOCK1;

    // Reset value 1 lets source 0 win the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (xfer && (xfer_last || force_rel)) begin
            rr_last <= (state == LOCK1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.req0 && bus.req1) begin
                        state <= both_grant;
                    end else if (bus.req0) begin
                        state <= LOCK0;
                    end else if (bus.req1) begin
                        state <= LOCK1;
                    end
                end
                LOCK0, LOCK1: begin
                    if (xfer) begin
                        if (xfer_last || force_rel) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (force_rel) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: per-source expected byte queues, grant-order log.
module tb_uart_tx_arbiter;

    localparam int MAX_PKT = 4;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic busy;
    logic owner;
    logic err;

    uart_tx_arb_if intf();

    uart_tx_arbiter #(.MAX_PKT(MAX_PKT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (intf.slave),
        .err_clr (err_clr),
        .busy    (busy),
        .owner   (owner),
        .err     (err)
    );

    always #5 clk = ~clk;

    byte_t src0_q[$];
    byte_t src1_q[$];
    byte_t exp0_q[$];
    byte_t exp1_q[$];
    int    grant_log[$];
    int    exp_order[4];

    int   n_chk = 0;
    int   n_fail = 0;
    logic en0 = 1'b0;
    logic en1 = 1'b0;
    logic busy_prev = 1'b0;
    int   sample_idx;
    int   first_ack;
    int   last_ack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic present();
        intf.req0 = en0 && (src0_q.size() > 0);
        intf.req1 = en1 && (src1_q.size() > 0);
        if (src0_q.size() > 0) begin
            intf.data0 = src0_q[0].dat;
            intf.last0 = src0_q[0].last;
        end else begin
            intf.data0 = 8'h00;
            intf.last0 = 1'b0;
        end
        if (src1_q.size() > 0) begin
            intf.data1 = src1_q[0].dat;
            intf.last1 = src1_q[0].last;
        end else begin
            intf.data1 = 8'h00;
            intf.last1 = 1'b0;
        end
    endtask

    task automatic load(input int src, input logic [7:0] dat, input logic last, input logic expected);
        byte_t b;
        b.dat  = dat;
        b.last = last;
        if (src == 0) begin
            src0_q.push_back(b);
            if (expected) exp0_q.push_back(b);
        end else begin
            src1_q.push_back(b);
            if (expected) exp1_q.push_back(b);
        end
    endtask

    // Sample on the falling edge; retire acked bytes just after the next rising edge.
    task automatic run_cycles(input int n);
        logic  a0;
        logic  a1;
        byte_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_idx++;
            a0 = intf.ack0;
            a1 = intf.ack1;
            if (busy && !busy_prev) grant_log.push_back(int'(owner));
            busy_prev = busy;
            check_eq("ack_onehot", 32'(a0 & a1), 32'd0);
            check_eq("wr_eq_acks", 32'(intf.wr), 32'(a0 | a1));
            if (intf.full) check_eq("no_wr_when_full", 32'({intf.wr, a0, a1}), 32'd0);
            if (a0) begin
                if (first_ack < 0) first_ack = sample_idx;
                last_ack = sample_idx;
                check_eq("sb0_nonempty", 32'(exp0_q.size() != 0), 32'd1);
                if (exp0_q.size() != 0) begin
                    e = exp0_q.pop_front();
                    check_eq("wr_data_src0", 32'(intf.wr_data), 32'(e.dat));
                end
            end
            if (a1) begin
                check_eq("sb1_nonempty", 32'(exp1_q.size() != 0), 32'd1);
                if (exp1_q.size() != 0) begin
                    e = exp1_q.pop_front();
                    check_eq("wr_data_src1", 32'(intf.wr_data), 32'(e.dat));
                end
            end
            @(posedge clk);
            #1;
            if (a0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (a1 && src1_q.size() > 0) void'(src1_q.pop_front());
            present();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en0       = 1'b0;
        en1       = 1'b0;
        err_clr   = 1'b0;
        intf.full = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        present();
        run_cycles(2);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_wr", 32'(intf.wr), 32'd0);
        check_eq("rst_acks", 32'({intf.ack0, intf.ack1}), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
    endtask

    initial begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        intf.full = 1'b0;
        present();

        // Single source, three-byte packet.
        do_reset();
        rst = 1'b0;
        load(0, 8'h41, 1'b0, 1'b1);
        load(0, 8'h42, 1'b0, 1'b1);
        load(0, 8'h43, 1'b1, 1'b1);
        en0 = 1'b1;
        sample_idx = 0;
        first_ack  = -1;
        last_ack   = -1;
        grant_log.delete();
        present();
        #1;
        check_eq("idle_no_ack", 32'(intf.ack0), 32'd0);
        run_cycles(5);
        check_eq("first_ack_cycle", 32'(first_ack), 32'd2);
        check_eq("last_ack_cycle", 32'(last_ack), 32'd4);
        check_eq("single_busy_drop", 32'(busy), 32'd0);
        check_eq("single_sb_empty", 32'(exp0_q.size()), 32'd0);
        check_eq("single_grants", 32'(grant_log.size()), 32'd1);

        // Contention from reset, two 2-byte packets per source.
        do_reset();
        rst = 1'b0;
        load(0, 8'h10, 1'b0, 1'b1); load(0, 8'h11, 1'b1, 1'b1);
        load(0, 8'h12, 1'b0, 1'b1); load(0, 8'h13, 1'b1, 1'b1);
        load(1, 8'h20, 1'b0, 1'b1); load(1, 8'h21, 1'b1, 1'b1);
        load(1, 8'h22, 1'b0, 1'b1); load(1, 8'h23, 1'b1, 1'b1);
        en0 = 1'b1;
        en1 = 1'b1;
        grant_log.delete();
        present();
        run_cycles(14);
        check_eq("cont_grant_cnt", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check_eq($sformatf("cont_grant%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        end
        check_eq("cont_sb0_empty", 32'(exp0_q.size()), 32'd0);
        check_eq("cont_sb1_empty", 32'(exp1_q.size()), 32'd0);

        // Overlength on source 1: six bytes, no last, MAX_PKT = 4.
        en0 = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 6; i++) load(1, 8'(8'h30 + i), 1'b0, (i < 4) ? 1'b1 : 1'b0);
        present();
        run_cycles(4);
        check_eq("ovl_err_before", 32'(err), 32'd0);
        check_eq("ovl_busy_before", 32'(busy), 32'd1);
        run_cycles(1);
        en1 = 1'b0;
        src1_q.delete();
        present();
        check_eq("ovl_err_set", 32'(err), 32'd1);
        check_eq("ovl_released", 32'(busy), 32'd0);
        check_eq("ovl_sb_empty", 32'(exp1_q.size()), 32'd0);
        run_cycles(2);
        check_eq("ovl_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        run_cycles(1);
        err_clr = 1'b0;
        check_eq("ovl_err_clr", 32'(err), 32'd0);

        // Backpressure: full for five cycles after the first byte.
        load(0, 8'h50, 1'b0, 1'b1);
        load(0, 8'h51, 1'b0, 1'b1);
        load(0, 8'h52, 1'b0, 1'b1);
        load(0, 8'h53, 1'b1, 1'b1);
        en0 = 1'b1;
        present();
        run_cycles(2);
        intf.full = 1'b1;
        run_cycles(5);
        check_eq("bp_busy_held", 32'(busy), 32'd1);
        check_eq("bp_owner", 32'(owner), 32'd0);
        check_eq("bp_pending", 32'(exp0_q.size()), 32'd3);
        intf.full = 1'b0;
        run_cycles(4);
        check_eq("bp_sb_empty", 32'(exp0_q.size()), 32'd0);
        check_eq("bp_no_err_at_max", 32'(err), 32'd0);
        check_eq("bp_busy_drop", 32'(busy), 32'd0);

        // Reset after two of five bytes; previous winner was source 0.
        for (int i = 0; i < 5; i++) load(0, 8'(8'h60 + i), (i == 4) ? 1'b1 : 1'b0, (i < 2) ? 1'b1 : 1'b0);
        en0 = 1'b1;
        present();
        run_cycles(3);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        en0 = 1'b0;
        present();
        run_cycles(1);
        check_eq("mid_rst_idle", 32'(busy), 32'd0);
        check_eq("mid_rst_no_err", 32'(err), 32'd0);
        check_eq("mid_sb_empty", 32'(exp0_q.size()), 32'd0);
        rst = 1'b0;
        src0_q.delete();
        load(0, 8'h70, 1'b1, 1'b1);
        load(1, 8'h80, 1'b1, 1'b1);
        en0 = 1'b1;
        en1 = 1'b1;
        grant_log.delete();
        present();
        run_cycles(6);
        check_eq("post_rst_grant_cnt", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 0) check_eq("post_rst_first", 32'(grant_log[0]), 32'd0);
        check_eq("post_rst_sb0", 32'(exp0_q.size()), 32'd0);
        check_eq("post_rst_sb1", 32'(exp1_q.size()), 32'd0);
        check_eq("final_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_PKT, default 64: maximum bytes per packet before forced release.
REQ-002 Parameter CNT_W, default 7: byte-counter width; SHALL satisfy 2^CNT_W >= MAX_PKT.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports req0/req1, input, 1: source n presents a valid byte.
REQ-006 Ports data0/data1, input, 8: byte from source n.
REQ-007 Ports last0/last1, input, 1: presented byte is the final byte of its packet.
REQ-008 Ports ack0/ack1, output, 1: byte from source n is accepted this cycle.
REQ-009 Port full, input, 1: transmit FIFO full flag.
REQ-010 Port wr, output, 1: write strobe to the transmit FIFO.
REQ-011 Port wr_data, output, 8: byte to the transmit FIFO.
REQ-012 Port busy, output, 1: a packet grant is held.
REQ-013 Port owner, output, 1: index of the granted source; valid while busy.
REQ-014 Port err, output, 1: sticky flag, forced release occurred.
REQ-015 Port err_clr, input, 1: clears err.

Function
REQ-016 The block SHALL be an FSM with states IDLE, LOCK0 and LOCK1; packets are granted atomically, with no byte interleaving.
REQ-017 IDLE: req0 only goes to LOCK0; req1 only goes to LOCK1; both go to the source not served last (rr_last); neither stays in IDLE.
REQ-018 No byte SHALL be accepted in IDLE; first-byte latency from req to ack is one cycle minimum.
REQ-019 LOCKn: ackn = reqn & ~full; the other ack is 0.
REQ-020 wr SHALL equal ack0 | ack1, and wr_data SHALL equal the granted source's data; both are combinational, with zero latency.
REQ-021 A byte transfers when reqn & ackn; the byte counter (CNT_W bits) SHALL increment per transfer and clear on entry to LOCKn.
REQ-022 A transfer with lastn SHALL return the FSM to IDLE and set rr_last to n.
REQ-023 A transfer without lastn while counter == MAX_PKT-1 SHALL return the FSM to IDLE, set rr_last to n, and set err.
REQ-024 While full is high, nothing SHALL be accepted, and the FSM and counter SHALL hold.
REQ-025 Dropping reqn mid-packet SHALL keep the grant; only last or forced release frees it.
REQ-026 A packet end with the other source pending SHALL give IDLE for one cycle, then grant the other source (one-cycle bubble).
REQ-027 Simultaneous err set and err_clr: set wins.
REQ-028 busy = (state != IDLE); owner = (state == LOCK1).

Reset
REQ-029 rst SHALL force state IDLE, counter 0, rr_last 1 (source 0 wins first), and err 0; ack0, ack1, wr and busy read 0 next cycle.
REQ-030 rst mid-packet SHALL abandon the packet without setting err; the partial bytes already in the FIFO remain.

Configuration
REQ-031 Macro UART_TX_ARB_FIXED_PRIO_EN: when defined, IDLE with both requests SHALL always grant source 0, and rr_last is unused.
REQ-032 Without UART_TX_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-017.

Structure
REQ-033 The shared UART package SHALL hold the FSM state encoding (2 bits: IDLE=0, LOCK0=1, LOCK1=2) and the default MAX_PKT constant.
REQ-034 The block SHALL be flat with no sub-module; the parent instantiates it next to the UART transmit FIFO/transmitter pair, with wr/wr_data/full wired directly.

Verification
REQ-035 Single source: req0 with a 3-byte packet 0x41,0x42,0x43 (last on 0x43), full=0 -> ack0 on cycles 2-4, wr_data sequence 0x41,0x42,0x43, busy drops after the last byte.
REQ-036 Contention: req0 and req1 both asserted from reset with 2-byte packets each -> source 0 packet, one IDLE cycle, then source 1 packet; repeated contention alternates (fixed-priority build: source 0 always wins).
REQ-037 Backpressure: full=1 for 5 cycles mid-packet -> wr=0, ack=0 throughout, counter held, resumes on the next byte with no loss or duplication.
REQ-038 Overlength: MAX_PKT=4, source 1 sends 6 bytes with no last -> 4 accepted, err=1, grant released; err_clr clears err.
REQ-039 Reset mid-packet: rst after 2 of 5 bytes -> IDLE, err=0, next grant goes to source 0 when both request.
